// File: rtl/npi_frame_writer.sv
// Write-side NPI frame writer: packs FSL pixel pairs into 64-bit words, writes 128-byte bursts
// to MPMC frame memory and returns a frame-done token over FSL master.
module npi_frame_writer #(
  parameter int C_PI_ADDR_WIDTH     = 32,
  parameter int C_PI_DATA_WIDTH     = 64,
  parameter int C_PI_BE_WIDTH       = 8,
  parameter int C_PI_RDWDADDR_WIDTH = 4,
  parameter int C_FRAME_PIXELS      = 307200
) (
  input  logic                           FSL_Clk,
  input  logic                           FSL_Rst,
  output logic                           FSL_S_Read,
  input  logic [31:0]                    FSL_S_Data,
  input  logic                           FSL_S_Control,
  input  logic                           FSL_S_Exists,
  output logic                           FSL_M_Write,
  output logic [31:0]                    FSL_M_Data,
  output logic                           FSL_M_Control,
  input  logic                           FSL_M_Full,
  output logic [C_PI_ADDR_WIDTH-1:0]     XIL_NPI_Addr,
  output logic                           XIL_NPI_AddrReq,
  input  logic                           XIL_NPI_AddrAck,
  output logic                           XIL_NPI_RNW,
  output logic [3:0]                     XIL_NPI_Size,
  output logic [C_PI_DATA_WIDTH-1:0]     XIL_NPI_WrFIFO_Data,
  output logic [C_PI_BE_WIDTH-1:0]       XIL_NPI_WrFIFO_BE,
  output logic                           XIL_NPI_WrFIFO_Push,
  input  logic                           XIL_NPI_WrFIFO_AlmostFull,
  output logic                           XIL_NPI_WrFIFO_Flush,
  input  logic                           XIL_NPI_WrFIFO_Empty,
  input  logic [C_PI_DATA_WIDTH-1:0]     XIL_NPI_RdFIFO_Data,
  input  logic                           XIL_NPI_RdFIFO_Empty,
  input  logic [C_PI_RDWDADDR_WIDTH-1:0] XIL_NPI_RdFIFO_RdWdAddr,
  input  logic [1:0]                     XIL_NPI_RdFIFO_Latency,
  output logic                           XIL_NPI_RdFIFO_Pop,
  output logic                           XIL_NPI_RdFIFO_Flush,
  output logic                           XIL_NPI_RdModWr,
  input  logic                           XIL_NPI_InitDone,
  output logic [31:0]                    FRAMECNT_Port
);

  typedef enum logic [1:0] {IDLE, FILL, REQ, DONE} state_t;

  state_t                       state_q, state_d;
  logic                         s_read, addr_req, m_write;
  logic [31:0]                  base_q, hold_q, pix_cnt_q, frame_cnt_q;
  logic                         hold_valid_q, push_q, flush_q;
  logic [3:0]                   beat_q;
  logic [C_PI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_PI_DATA_WIDTH-1:0]   wr_data_q;
  logic                         last_burst;
  logic                         unused_inputs;

  assign unused_inputs = ^{XIL_NPI_WrFIFO_Empty, XIL_NPI_RdFIFO_Data, XIL_NPI_RdFIFO_Empty,
                           XIL_NPI_RdFIFO_RdWdAddr, XIL_NPI_RdFIFO_Latency};

  assign last_burst = (pix_cnt_q + 32'd32) == 32'(C_FRAME_PIXELS);

  always_ff @(posedge FSL_Clk or negedge FSL_Rst) begin
    if (!FSL_Rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Combinational strobes are gated by reset so every output is quiet while it is held.
  always_comb begin
    state_d  = state_q;
    s_read   = 1'b0;
    addr_req = 1'b0;
    m_write  = 1'b0;
    if (FSL_Rst) begin
      case (state_q)
        IDLE: begin
          s_read = FSL_S_Exists & XIL_NPI_InitDone;
          if (s_read && FSL_S_Control) state_d = FILL;
        end
        FILL: begin
          s_read = FSL_S_Exists & ~XIL_NPI_WrFIFO_AlmostFull & ~push_q;
          if (push_q && beat_q == 4'd15) state_d = REQ;
        end
        REQ: begin
          addr_req = 1'b1;
          if (XIL_NPI_AddrAck) state_d = last_burst ? DONE : FILL;
        end
        DONE: begin
          m_write = ~FSL_M_Full;
          if (m_write) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge FSL_Clk or negedge FSL_Rst) begin
    if (!FSL_Rst) begin
      base_q       <= '0;
      addr_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      wr_data_q    <= '0;
      push_q       <= 1'b0;
      flush_q      <= 1'b0;
      beat_q       <= '0;
      pix_cnt_q    <= '0;
      frame_cnt_q  <= '0;
    end else begin
      push_q  <= 1'b0;
      flush_q <= 1'b0;
      if (push_q) beat_q <= beat_q + 4'd1;
      if (state_q == REQ && XIL_NPI_AddrAck) begin
        addr_q    <= addr_q + C_PI_ADDR_WIDTH'(128);
        pix_cnt_q <= pix_cnt_q + 32'd32;
      end
      if (m_write) frame_cnt_q <= frame_cnt_q + 32'd1;
      // A control word seen in FILL aborts the frame in progress and restarts at the new base.
      if (s_read && FSL_S_Control) begin
        base_q       <= FSL_S_Data;
        addr_q       <= C_PI_ADDR_WIDTH'(FSL_S_Data);
        hold_valid_q <= 1'b0;
        beat_q       <= '0;
        pix_cnt_q    <= '0;
        flush_q      <= (state_q == FILL);
      end else if (s_read && state_q == FILL) begin
        if (!hold_valid_q) begin
          hold_q       <= FSL_S_Data;
          hold_valid_q <= 1'b1;
        end else begin
          wr_data_q    <= C_PI_DATA_WIDTH'({FSL_S_Data, hold_q});
          push_q       <= 1'b1;
          hold_valid_q <= 1'b0;
        end
      end
    end
  end

  assign FSL_S_Read           = s_read;
  assign FSL_M_Write          = m_write;
  assign FSL_M_Data           = m_write ? base_q : 32'd0;
  assign FSL_M_Control        = m_write;
  assign XIL_NPI_Addr         = addr_q;
  assign XIL_NPI_AddrReq      = addr_req;
  assign XIL_NPI_RNW          = 1'b0;
  assign XIL_NPI_Size         = 4'd4;
  assign XIL_NPI_WrFIFO_Data  = wr_data_q;
  assign XIL_NPI_WrFIFO_BE    = '1;
  assign XIL_NPI_WrFIFO_Push  = push_q;
  assign XIL_NPI_WrFIFO_Flush = flush_q;
  assign XIL_NPI_RdFIFO_Pop   = 1'b0;
  assign XIL_NPI_RdFIFO_Flush = 1'b0;
  assign XIL_NPI_RdModWr      = 1'b0;
  assign FRAMECNT_Port        = frame_cnt_q;

endmodule

// File: tb/tb_npi_frame_writer.sv
// Directed-plus-random bench for npi_frame_writer with a pixel-index reference model
// (64-pixel frames) predicting NPI words, burst addresses and frame tokens.
module tb_npi_frame_writer;
  localparam int FRAME = 64;

  logic        FSL_Clk = 1'b0;
  logic        FSL_Rst;
  logic        FSL_S_Read, FSL_S_Control, FSL_S_Exists;
  logic [31:0] FSL_S_Data;
  logic        FSL_M_Write, FSL_M_Control, FSL_M_Full;
  logic [31:0] FSL_M_Data, FRAMECNT_Port;
  logic [31:0] XIL_NPI_Addr;
  logic        XIL_NPI_AddrReq, XIL_NPI_AddrAck, XIL_NPI_RNW;
  logic [3:0]  XIL_NPI_Size;
  logic [63:0] XIL_NPI_WrFIFO_Data;
  logic [7:0]  XIL_NPI_WrFIFO_BE;
  logic        XIL_NPI_WrFIFO_Push, XIL_NPI_WrFIFO_AlmostFull, XIL_NPI_WrFIFO_Flush;
  logic        XIL_NPI_RdFIFO_Pop, XIL_NPI_RdFIFO_Flush, XIL_NPI_RdModWr, XIL_NPI_InitDone;

  npi_frame_writer #(.C_FRAME_PIXELS(FRAME)) dut (
    .FSL_Clk(FSL_Clk), .FSL_Rst(FSL_Rst),
    .FSL_S_Read(FSL_S_Read), .FSL_S_Data(FSL_S_Data), .FSL_S_Control(FSL_S_Control),
    .FSL_S_Exists(FSL_S_Exists),
    .FSL_M_Write(FSL_M_Write), .FSL_M_Data(FSL_M_Data), .FSL_M_Control(FSL_M_Control),
    .FSL_M_Full(FSL_M_Full),
    .XIL_NPI_Addr(XIL_NPI_Addr), .XIL_NPI_AddrReq(XIL_NPI_AddrReq), .XIL_NPI_AddrAck(XIL_NPI_AddrAck),
    .XIL_NPI_RNW(XIL_NPI_RNW), .XIL_NPI_Size(XIL_NPI_Size),
    .XIL_NPI_WrFIFO_Data(XIL_NPI_WrFIFO_Data), .XIL_NPI_WrFIFO_BE(XIL_NPI_WrFIFO_BE),
    .XIL_NPI_WrFIFO_Push(XIL_NPI_WrFIFO_Push), .XIL_NPI_WrFIFO_AlmostFull(XIL_NPI_WrFIFO_AlmostFull),
    .XIL_NPI_WrFIFO_Flush(XIL_NPI_WrFIFO_Flush), .XIL_NPI_WrFIFO_Empty(1'b1),
    .XIL_NPI_RdFIFO_Data(64'd0), .XIL_NPI_RdFIFO_Empty(1'b1), .XIL_NPI_RdFIFO_RdWdAddr(4'd0),
    .XIL_NPI_RdFIFO_Latency(2'd0), .XIL_NPI_RdFIFO_Pop(XIL_NPI_RdFIFO_Pop),
    .XIL_NPI_RdFIFO_Flush(XIL_NPI_RdFIFO_Flush), .XIL_NPI_RdModWr(XIL_NPI_RdModWr),
    .XIL_NPI_InitDone(XIL_NPI_InitDone), .FRAMECNT_Port(FRAMECNT_Port)
  );

  always #5 FSL_Clk = ~FSL_Clk;

  int checks = 0, passes = 0, fails = 0;

  // FSL input stream ({control, data}) and the model's predictions.
  logic [32:0] feed[$];
  logic [63:0] exp_words[$];
  logic [31:0] exp_addrs[$], exp_tokens[$];
  bit          active = 0;
  int          n_pix = 0, frames_exp = 0;
  logic [31:0] cur_base = '0, prev_pix = '0;

  bit ack_en = 1, af_check = 0, rt_in_frame = 0, expect_push = 0;
  int req_age = 0, rt_pix = 0, flush_cnt = 0, token_cnt = 0, push_cnt = 0;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_ctrl(input logic [31:0] base);
    feed.push_back({1'b1, base});
    active   = 1;
    n_pix    = 0;
    cur_base = base;
  endtask

  // Pixel k (1-based) of a frame: even k closes a pair, every 32nd closes burst k/32-1.
  task automatic add_pixel(input logic [31:0] p);
    feed.push_back({1'b0, p});
    if (active) begin
      n_pix++;
      if (n_pix % 2 == 0) exp_words.push_back({p, prev_pix});
      else prev_pix = p;
      if (n_pix % 32 == 0) exp_addrs.push_back(cur_base + 32'(128 * (n_pix / 32 - 1)));
      if (n_pix == FRAME) begin
        exp_tokens.push_back(cur_base);
        frames_exp++;
        active = 0;
      end
    end
  endtask

  // One clock: present the head of the feed, observe at the falling edge, return at posedge+1.
  task automatic apply_stimulus();
    if (feed.size() > 0) begin
      FSL_S_Exists  = 1'b1;
      FSL_S_Control = feed[0][32];
      FSL_S_Data    = feed[0][31:0];
    end else begin
      FSL_S_Exists  = 1'b0;
      FSL_S_Control = 1'b0;
      FSL_S_Data    = '0;
    end
    @(negedge FSL_Clk);
    XIL_NPI_AddrAck = 1'b0;
    if (af_check) check_output("stall_read", FSL_S_Read, 0);
    if (expect_push) check_output("push_latency", XIL_NPI_WrFIFO_Push, 1);
    expect_push = 0;
    if (FSL_S_Read && feed.size() > 0) begin
      if (feed[0][32]) begin
        rt_in_frame = 1;
        rt_pix      = 0;
      end else if (rt_in_frame) begin
        rt_pix++;
        if (rt_pix % 2 == 0) expect_push = 1;
        if (rt_pix == FRAME) rt_in_frame = 0;
      end
      void'(feed.pop_front());
    end
    if (XIL_NPI_WrFIFO_Push) begin
      push_cnt++;
      if (exp_words.size() == 0) check_output("push_unexpected", XIL_NPI_WrFIFO_Push, 0);
      else check_output("push_data", XIL_NPI_WrFIFO_Data, exp_words.pop_front());
    end
    if (XIL_NPI_WrFIFO_Flush) flush_cnt++;
    if (XIL_NPI_AddrReq) begin
      req_age++;
      if (exp_addrs.size() == 0) check_output("req_unexpected", XIL_NPI_AddrReq, 0);
      else begin
        check_output("req_addr", XIL_NPI_Addr, exp_addrs[0]);
        if (ack_en && req_age == 4) begin
          XIL_NPI_AddrAck = 1'b1;
          void'(exp_addrs.pop_front());
        end
      end
    end else begin
      req_age = 0;
    end
    if (FSL_M_Full) check_output("write_while_full", FSL_M_Write, 0);
    if (FSL_M_Write) begin
      token_cnt++;
      if (exp_tokens.size() == 0) check_output("token_unexpected", FSL_M_Write, 0);
      else begin
        check_output("token_data", FSL_M_Data, exp_tokens.pop_front());
        check_output("token_ctrl", FSL_M_Control, 1);
      end
    end
    @(posedge FSL_Clk);
    #1;
  endtask

  task automatic run_until(input string tag, input bit wait_tokens, input int budget);
    int  n = 0;
    bit  done;
    done = 0;
    while (n < budget) begin
      done = feed.size() == 0 && exp_words.size() == 0 && exp_addrs.size() == 0 &&
             (!wait_tokens || exp_tokens.size() == 0);
      if (done) break;
      apply_stimulus();
      n++;
    end
    check_output(tag, done, 1);
  endtask

  initial begin
    FSL_Rst = 1'b0;
    FSL_S_Exists = 1'b1; FSL_S_Control = 1'b1; FSL_S_Data = 32'hDEAD_BEEF;
    FSL_M_Full = 1'b0; XIL_NPI_AddrAck = 1'b0; XIL_NPI_WrFIFO_AlmostFull = 1'b0;
    XIL_NPI_InitDone = 1'b1;
    #12;
    check_output("rst_s_read", FSL_S_Read, 0);
    check_output("rst_addr_req", XIL_NPI_AddrReq, 0);
    check_output("rst_push", XIL_NPI_WrFIFO_Push, 0);
    check_output("rst_flush", XIL_NPI_WrFIFO_Flush, 0);
    check_output("rst_m_write", FSL_M_Write, 0);
    check_output("rst_m_data", FSL_M_Data, 0);
    check_output("rst_be", XIL_NPI_WrFIFO_BE, 8'hFF);
    check_output("rst_size", XIL_NPI_Size, 4);
    check_output("rst_rnw", XIL_NPI_RNW, 0);
    check_output("rst_addr", XIL_NPI_Addr, 0);
    check_output("rst_framecnt", FRAMECNT_Port, 0);
    check_output("rst_rd_pop", {XIL_NPI_RdFIFO_Pop, XIL_NPI_RdFIFO_Flush, XIL_NPI_RdModWr}, 0);
    FSL_S_Exists = 1'b0;
    @(negedge FSL_Clk) FSL_Rst = 1'b1;
    @(posedge FSL_Clk);
    #1;

    $display("[TB] InitDone gating and discard of stray pixels");
    XIL_NPI_InitDone = 1'b0;
    add_pixel($urandom()); add_pixel($urandom());
    repeat (4) apply_stimulus();
    check_output("initdone_block", feed.size(), 2);
    XIL_NPI_InitDone = 1'b1;
    run_until("junk_drain", 1, 20);

    $display("[TB] Frame A at 0x01000000, token held by FSL_M_Full");
    FSL_M_Full = 1'b1;
    token_cnt  = 0;
    add_ctrl(32'h0100_0000);
    for (int i = 0; i < 32; i++) add_pixel(32'(i));
    for (int i = 0; i < 32; i++) add_pixel($urandom());
    run_until("frameA_data", 0, 2000);
    repeat (5) apply_stimulus();
    check_output("frameA_held", token_cnt, 0);
    FSL_M_Full = 1'b0;
    run_until("frameA_token", 1, 50);
    repeat (3) apply_stimulus();
    check_output("frameA_one_token", token_cnt, 1);
    check_output("framecnt_1", FRAMECNT_Port, frames_exp);

    $display("[TB] Frame B at 0x02000000 with AlmostFull stall");
    add_ctrl(32'h0200_0000);
    for (int i = 0; i < FRAME; i++) add_pixel($urandom());
    for (int i = 0; i < 500 && feed.size() > 54; i++) apply_stimulus();
    check_output("stall_reached", feed.size() <= 54, 1);
    XIL_NPI_WrFIFO_AlmostFull = 1'b1;
    af_check = 1;
    repeat (10) apply_stimulus();
    XIL_NPI_WrFIFO_AlmostFull = 1'b0;
    af_check = 0;
    run_until("frameB", 1, 2000);
    repeat (3) apply_stimulus();
    check_output("framecnt_2", FRAMECNT_Port, frames_exp);

    $display("[TB] Abort after 7 pixels, restart at 0x03000000");
    add_ctrl(32'h0500_0000);
    for (int i = 0; i < 7; i++) add_pixel($urandom());
    run_until("partial", 1, 500);
    repeat (3) apply_stimulus();
    flush_cnt = 0;
    token_cnt = 0;
    add_ctrl(32'h0300_0000);
    for (int i = 0; i < FRAME; i++) add_pixel($urandom());
    run_until("frameC", 1, 2000);
    repeat (3) apply_stimulus();
    check_output("flush_once", flush_cnt, 1);
    check_output("frameC_one_token", token_cnt, 1);
    check_output("framecnt_3", FRAMECNT_Port, frames_exp);

    $display("[TB] Reset asserted while requesting");
    ack_en = 0;
    add_ctrl(32'h0600_0000);
    for (int i = 0; i < 32; i++) add_pixel($urandom());
    for (int i = 0; i < 500 && !XIL_NPI_AddrReq; i++) apply_stimulus();
    check_output("req_reached", XIL_NPI_AddrReq, 1);
    FSL_Rst = 1'b0;
    #1;
    check_output("rst_req_drop", XIL_NPI_AddrReq, 0);
    check_output("rst_no_flush", XIL_NPI_WrFIFO_Flush, 0);
    check_output("rst_framecnt_clr", FRAMECNT_Port, 0);
    feed.delete(); exp_words.delete(); exp_addrs.delete(); exp_tokens.delete();
    active = 0; frames_exp = 0; rt_in_frame = 0; expect_push = 0; ack_en = 1;
    XIL_NPI_AddrAck = 1'b0;
    @(negedge FSL_Clk) FSL_Rst = 1'b1;
    @(posedge FSL_Clk);
    #1;
    push_cnt  = 0;
    flush_cnt = 0;
    for (int i = 0; i < 4; i++) add_pixel($urandom());
    run_until("post_reset_discard", 1, 30);
    repeat (4) apply_stimulus();
    check_output("post_reset_no_push", push_cnt, 0);
    check_output("post_reset_no_flush", flush_cnt, 0);
    check_output("post_reset_req", XIL_NPI_AddrReq, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
